// File: rtl/memory.sv
// Word-addressed main-memory model behind the L1: one request at a time, fixed
// access latency, single-cycle response. Contents power up as mem[i] = i.
module memory #(
    parameter int DEPTH_WORDS = 65536,
    parameter int LATENCY     = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        l1_mem_valid,
    input  logic        l1_mem_store,
    input  logic [31:0] l1_mem_addr,
    input  logic [31:0] l1_mem_wdata,
    output logic [31:0] mem_l1_rdata,
    output logic        mem_l1_valid
);
    localparam int AW = $clog2(DEPTH_WORDS);

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_BUSY = 1'b1;

    typedef logic [31:0] mem_t [DEPTH_WORDS];

    function automatic mem_t init_pattern();
        mem_t m;
        for (int i = 0; i < DEPTH_WORDS; i++) begin
            m[i] = 32'(i);
        end
        return m;
    endfunction

    // Power-up contents only; reset never touches the array.
    mem_t mem_q = init_pattern();

    logic          state_q, state_d;
    logic [7:0]    cnt_q, cnt_d;
    logic          store_q, store_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          valid_q, valid_d;
    logic          fire;

    generate
        if (AW + 2 < 32) begin : g_alias
            logic unused_addr_bits;
            assign unused_addr_bits = ^{l1_mem_addr[1:0], l1_mem_addr[31:AW+2]};
        end else begin : g_full
            logic unused_addr_bits;
            assign unused_addr_bits = ^l1_mem_addr[1:0];
        end
    endgenerate

    assign fire = (state_q == ST_BUSY) && (cnt_q == 8'd0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        store_d = store_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        valid_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (l1_mem_valid) begin
                    state_d = ST_BUSY;
                    cnt_d   = 8'(LATENCY - 1);
                    store_d = l1_mem_store;
                    idx_d   = l1_mem_addr[AW+1:2];
                    wdata_d = l1_mem_wdata;
                end
            end
            default: begin
                if (fire) begin
                    state_d = ST_IDLE;
                    valid_d = 1'b1;
                    // Store echoes the written word back as its response data.
                    rdata_d = store_q ? wdata_q : mem_q[idx_q];
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 8'd0;
            store_q <= 1'b0;
            idx_q   <= '0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            store_q <= store_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            valid_q <= valid_d;
        end
    end

    // fire is cleared asynchronously by reset, so an aborted store never commits.
    always_ff @(posedge clk) begin
        if (fire && store_q) begin
            mem_q[idx_q] <= wdata_q;
        end
    end

    assign mem_l1_rdata = rdata_q;
    assign mem_l1_valid = valid_q;
endmodule

// File: tb/tb_memory.sv
// Directed bench for memory: power-up pattern, store/load-back, busy drop,
// address aliasing and asynchronous reset during an access.
module tb_memory;
    localparam int LAT = 10;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        l1_mem_valid = 1'b0;
    logic        l1_mem_store = 1'b0;
    logic [31:0] l1_mem_addr = 32'd0;
    logic [31:0] l1_mem_wdata = 32'd0;
    logic [31:0] mem_l1_rdata;
    logic        mem_l1_valid;

    int n_asserts = 0;
    int n_fail    = 0;

    memory #(.DEPTH_WORDS(65536), .LATENCY(LAT)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .l1_mem_valid (l1_mem_valid),
        .l1_mem_store (l1_mem_store),
        .l1_mem_addr  (l1_mem_addr),
        .l1_mem_wdata (l1_mem_wdata),
        .mem_l1_rdata (mem_l1_rdata),
        .mem_l1_valid (mem_l1_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Issue one request at a negedge; measure edges from accept to response.
    task automatic do_req(input string tag, input logic st, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [31:0] exp);
        int cyc;
        @(negedge clk);
        l1_mem_valid = 1'b1;
        l1_mem_store = st;
        l1_mem_addr  = addr;
        l1_mem_wdata = wd;
        @(negedge clk);
        l1_mem_valid = 1'b0;
        cyc = 0;
        while (!mem_l1_valid && cyc < 4 * LAT) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_lat"}, 32'(cyc), 32'(LAT));
        check({tag, "_data"}, mem_l1_rdata, exp);
        @(negedge clk);
        check({tag, "_pulse"}, {31'd0, mem_l1_valid}, 32'd0);
        $display("txn %s st=%0b addr=0x%08h rdata=0x%08h lat=%0d", tag, st, addr, mem_l1_rdata, cyc);
    endtask

    // Count response pulses over a window where none should appear.
    task automatic quiet(input string tag, input int cycles);
        int seen;
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (mem_l1_valid) seen++;
        end
        check(tag, 32'(seen), 32'd0);
    endtask

    initial begin
        int cyc;
        int seen;

        // Reset held for three cycles with idle inputs.
        repeat (3) @(negedge clk);
        check("rst_valid", {31'd0, mem_l1_valid}, 32'd0);
        check("rst_rdata", mem_l1_rdata, 32'd0);
        rst_n = 1'b1;
        quiet("rst_release_quiet", 5);

        // Power-up pattern.
        do_req("ld0",  1'b0, 32'h0000_0000, 32'h0, 32'h0);
        do_req("ld4",  1'b0, 32'h0000_0004, 32'h0, 32'h1);
        do_req("ld40", 1'b0, 32'h0000_0040, 32'h0, 32'h10);

        // Store then load-back.
        do_req("st80",    1'b1, 32'h0000_0080, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        do_req("ld80",    1'b0, 32'h0000_0080, 32'h0,         32'hDEAD_BEEF);
        do_req("st10000", 1'b1, 32'h0001_0000, 32'hCAFE_BABE, 32'hCAFE_BABE);
        do_req("ld10000", 1'b0, 32'h0001_0000, 32'h0,         32'hCAFE_BABE);
        do_req("ld10004", 1'b0, 32'h0001_0004, 32'h0,         32'h0000_4001);

        // Store to 0x8 pulsed while BUSY must be dropped.
        @(negedge clk);
        l1_mem_valid = 1'b1; l1_mem_store = 1'b0; l1_mem_addr = 32'h4;
        @(negedge clk);
        l1_mem_valid = 1'b0;
        repeat (3) @(negedge clk);
        l1_mem_valid = 1'b1; l1_mem_store = 1'b1; l1_mem_addr = 32'h8; l1_mem_wdata = 32'h5555_AAAA;
        @(negedge clk);
        l1_mem_valid = 1'b0; l1_mem_store = 1'b0;
        cyc = 4; seen = 0;
        while (!mem_l1_valid && cyc < 4 * LAT) begin
            @(negedge clk);
            cyc++;
        end
        check("busy_lat", 32'(cyc), 32'(LAT));
        check("busy_data", mem_l1_rdata, 32'h1);
        $display("txn busy_ld4 rdata=0x%08h lat=%0d", mem_l1_rdata, cyc);
        quiet("busy_single_resp", 3 * LAT);
        do_req("ld8_after_drop", 1'b0, 32'h0000_0008, 32'h0, 32'h2);

        // Low-order bits and aliasing above the index.
        do_req("ld7",     1'b0, 32'h0000_0007, 32'h0, 32'h1);
        do_req("ld40004", 1'b0, 32'h0004_0004, 32'h0, 32'h1);

        // Asynchronous reset in the middle of a store.
        @(negedge clk);
        l1_mem_valid = 1'b1; l1_mem_store = 1'b1; l1_mem_addr = 32'h10; l1_mem_wdata = 32'h1234_5678;
        @(negedge clk);
        l1_mem_valid = 1'b0; l1_mem_store = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_rdata", mem_l1_rdata, 32'd0);
        check("midrst_valid", {31'd0, mem_l1_valid}, 32'd0);
        $display("txn midrst rdata=0x%08h valid=%0b", mem_l1_rdata, mem_l1_valid);
        @(negedge clk);
        rst_n = 1'b1;
        quiet("midrst_no_resp", LAT + 5);
        do_req("ld10_after_rst", 1'b0, 32'h0000_0010, 32'h0, 32'h4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end
endmodule
